// File: rtl/booth_mac_seq.sv
// Dot-product sequencer around the 4-bit signed Booth multiplier: issues one
// operand pair at a time, accumulates the 8-bit products, and hands out the sum.
module booth_mac_seq #(
  parameter int LEN     = 4,
  parameter int ACC_W   = 12,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_x,
  input  logic [3:0]       in_y,
  input  logic             in_last,
  output logic             mul_start,
  output logic [3:0]       mul_x,
  output logic [3:0]       mul_y,
  input  logic             mul_valid,
  input  logic [7:0]       mul_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [4:0]       out_count,
  output logic             out_err
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACCUM, DONE} stateT;

  stateT                   r_state;
  logic [3:0]              r_x;
  logic [3:0]              r_y;
  logic                    r_last;
  logic                    r_err;
  logic [7:0]              r_timer;
  logic signed [7:0]       r_prod;
  logic signed [ACC_W-1:0] r_acc;
  logic [4:0]              r_cnt;
  logic signed [ACC_W-1:0] w_prodExt;

  assign w_prodExt = ACC_W'(r_prod);

  // Every output is a register or a decode of r_state; nothing flows through from inputs.
  assign in_ready  = (r_state == IDLE);
  assign mul_start = (r_state == ISSUE);
  assign out_valid = (r_state == DONE);
  assign mul_x     = r_x;
  assign mul_y     = r_y;
  assign out_acc   = r_acc;
  assign out_count = r_cnt;
  assign out_err   = r_err;

  // Operand registers are only rewritten in IDLE, so the multiplier sees them
  // stable for the whole ISSUE..WAIT window while it re-reads the X bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_timer <= '0;
      r_prod  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x     <= in_x;
            r_y     <= in_y;
            r_last  <= in_last || (r_cnt == 5'(LEN - 1));
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_timer <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_timer <= r_timer + 8'd1;
          if (mul_valid) begin
            r_prod  <= mul_z;
            r_state <= ACCUM;
          end else if (r_timer == 8'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= DONE;
          end
        end
        ACCUM: begin
          r_acc   <= r_acc + w_prodExt;
          r_cnt   <= r_cnt + 5'd1;
          r_state <= r_last ? DONE : IDLE;
        end
        DONE: begin
          if (out_ready) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/booth_mac_seq.md
Name: booth_mac_seq

Overview:
Sequencer and accumulator wrapped around the team's 4-bit signed Booth multiplier. Accepts signed operand pairs over a valid/ready stream and issues each pair to the multiplier as a one-cycle start pulse. Captures each 8-bit product on the multiplier's valid pulse and sums the products into a signed accumulator. Emits the dot product after LEN pairs, or earlier on in_last, over a valid/ready result handshake.

Parameters:
LEN, 4, pairs per dot product (1..16)
ACC_W, 12, accumulator width in bits, two's complement (8 ≤ ACC_W ≤ 32)
TIMEOUT, 16, max WAIT cycles for mul_valid before error (2..255)

Ports:
clk  in  1  clock
rst  in  1  reset: one clock; reset is synchronous and active-high
in_valid  in  1  operand pair present
in_ready  out  1  block can accept a pair
in_x  in  4  signed multiplicand
in_y  in  4  signed multiplier
in_last  in  1  pair is the final one of this dot product (early terminate)
mul_start  out  1  one-cycle start pulse to multiplier
mul_x  out  4  multiplicand to multiplier
mul_y  out  4  multiplier operand to multiplier
mul_valid  in  1  multiplier product-ready pulse
mul_z  in  8  signed product from multiplier
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_acc  out  ACC_W  signed accumulated sum
out_count  out  5  number of products summed
out_err  out  1  result ended by timeout

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; acc, cnt, timer, err, operand and product registers all 0. Outputs after reset: in_ready=1; mul_start=0; mul_x=0, mul_y=0; out_valid=0; out_acc=0; out_count=0; out_err=0. rst takes priority over every other event, including mid-WAIT. A mul_valid arriving after the reset is ignored.
- States: IDLE, ISSUE, WAIT, ACCUM, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE. All outputs are registered or decoded from the state register; no combinational input-to-output path.
- IDLE: on in_valid&in_ready, latch in_x/in_y into the operand regs. Set last = in_last | (cnt==LEN-1). Go to ISSUE.
- ISSUE: mul_start=1 for exactly this one cycle; timer<=0; go to WAIT.
- mul_x/mul_y are driven from the operand regs and held stable from ISSUE through the end of WAIT. This is required because the multiplier re-reads X bits during its iterations.
- WAIT: timer increments each cycle.
  - If mul_valid=1: capture prod<=mul_z and go to ACCUM.
  - Otherwise, if timer==TIMEOUT-1: err<=1 and go to DONE; acc is unchanged.
  - mul_valid has priority over the timeout when both occur in the same cycle.
- mul_valid in any state other than WAIT is ignored.
- ACCUM: acc <= acc + sign_extend(prod) to ACC_W bits; wraps modulo 2^ACC_W with no saturation. cnt<=cnt+1. Go to DONE if last, else to IDLE.
- DONE: out_acc=acc, out_count=cnt and out_err=err, all held stable while out_valid=1 and out_ready=0. On out_ready=1: acc, cnt and err are cleared and the state goes to IDLE; in_ready=1 in the next cycle.
- Latency with the standard multiplier (mul_valid 5 cycles after the start pulse is sampled):
  - acceptance edge to mul_start high: 1 cycle.
  - acceptance to in_ready high again: 7 cycles.
  - acceptance of the last pair to out_valid high: 7 cycles.
- Back-to-back operation: at most one multiplication is outstanding; a new start is never issued while in WAIT.
- The multiplier's own reset is active-low asynchronous; the top level drives it from ~rst. This block does not generate it.

Test Plan:
- LEN=4, ACC_W=12, pairs (3,2),(-4,5),(7,-8),(-1,-1), in_last=0 -> one out_valid with out_acc=0xFBB (-69), out_count=4, out_err=0; exactly four mul_start pulses, each 1 cycle wide, in_ready high 7 cycles after each acceptance.
- First pair (-8,-8) with in_last=1 -> out_acc=64 (0x040), out_count=1, out_err=0; no second mul_start is issued.
- Multiplier model holds mul_valid=0 after the 2nd start (first product 6) -> out_valid exactly TIMEOUT=16 cycles after entering WAIT; out_acc=6, out_count=1, out_err=1. A late mul_valid is ignored.
- ACC_W=8, LEN=4, four pairs (-8,-8) -> out_acc=0x00 (256 wrapped), out_count=4. Also hold out_ready=0 for 3 cycles -> out_acc, out_count and out_err stable and in_ready=0 throughout; clear on the accepting cycle.
- Assert rst for 1 cycle while in WAIT -> next cycle in_ready=1, mul_start=0, out_valid=0, out_acc=0, out_count=0. A subsequent mul_valid pulse does not change the accumulator, and a fresh dot product of (2,3) gives out_acc=6.
- Drive in_valid=1 continuously with out_ready=1 -> pairs are accepted only in IDLE, with exactly one accepted pair per mul_start and mul_x/mul_y constant between each start and its mul_valid.
